// File: rtl/char_pkg.sv
// Shared types and defaults for the character classifier core.
package char_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACCUM,
    S_BIAS,
    S_ADDB,
    S_ARGMAX,
    S_DONE
  } state_t;

  localparam int N_PIX_D   = 784;
  localparam int N_CLASS_D = 10;
  localparam int PIX_W_D   = 8;
  localparam int WGT_W_D   = 8;
  localparam int ACC_W_D   = 32;

  // Low bit of class c's weight inside a packed ROM row.
  function automatic int wslice(input int c, input int w);
    return c * w;
  endfunction

  // Index width that stays legal for a single-class build.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/char_classify_core_if.sv
// Pixel stream handshake plus weight ROM read port of the classifier.
interface char_classify_core_if #(
  parameter int PIX_W   = 8,
  parameter int WGT_W   = 8,
  parameter int N_CLASS = 10,
  parameter int ADDR_W  = 10
);
  logic [PIX_W-1:0]         pix_data;
  logic                     pix_valid;
  logic                     pix_ready;
  logic [ADDR_W-1:0]        wgt_addr;
  logic                     wgt_en;
  logic [N_CLASS*WGT_W-1:0] wgt_rdata;

  // master: pixel source and ROM; slave: the classifier core
  modport master (
    output pix_data, pix_valid, wgt_rdata,
    input  pix_ready, wgt_addr, wgt_en
  );

  modport slave (
    input  pix_data, pix_valid, wgt_rdata,
    output pix_ready, wgt_addr, wgt_en
  );
endinterface

// File: rtl/char_argmax_seq.sv
// Sequential argmax, one class per cycle; strict greater wins so ties keep the lower index.
module char_argmax_seq
  import char_pkg::*;
#(
  parameter int N     = 10,
  parameter int ACC_W = 32,
  parameter int IDX_W = idx_w(N)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [N*ACC_W-1:0]      vec,
  output logic                    fin,
  output logic [IDX_W-1:0]        best_id,
  output logic signed [ACC_W-1:0] best
);

  logic [IDX_W-1:0]        idx;
  logic signed [ACC_W-1:0] cand;

  assign cand = $signed(vec[idx*ACC_W +: ACC_W]);
  // idx==0 doubles as "not scanning": compares always begin at class 1
  assign fin  = (idx == IDX_W'(N - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      idx     <= '0;
      best    <= '0;
      best_id <= '0;
    end else if (start) begin
      best    <= $signed(vec[ACC_W-1:0]);
      best_id <= '0;
      idx     <= (N > 1) ? IDX_W'(1) : '0;
    end else if (idx != '0) begin
      if (cand > best) begin
        best    <= cand;
        best_id <= idx;
      end
      idx <= fin ? '0 : idx + IDX_W'(1);
    end
  end

endmodule

// File: rtl/char_classify_core.sv
// Single-layer character classifier: streamed MAC over all classes, bias add, sequential argmax.
module char_classify_core
  import char_pkg::*;
#(
  parameter int N_PIX   = N_PIX_D,
  parameter int N_CLASS = N_CLASS_D,
  parameter int PIX_W   = PIX_W_D,
  parameter int WGT_W   = WGT_W_D,
  parameter int ACC_W   = ACC_W_D,
  parameter int ADDR_W  = 10
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  char_classify_core_if.slave           bus,
  output logic                          busy,
  output logic                          done,
  output logic [idx_w(N_CLASS)-1:0]     class_id,
  output logic signed [ACC_W-1:0]       class_score
);

  localparam int CID_W  = idx_w(N_CLASS);
  localparam int PROD_W = PIX_W + WGT_W + 1;

  state_t state_q, state_d;

  logic                    pix_rdy;
  logic                    rom_en;
  logic                    fire;
  logic                    ag_start;
  logic                    ag_fin;
  logic [ADDR_W-1:0]       pix_cnt;
  logic [ADDR_W-1:0]       wgt_addr_q;
  logic [PIX_W-1:0]        pix_reg;
  logic                    mac_vld;
  logic [N_CLASS*ACC_W-1:0] acc_flat;
  logic [CID_W-1:0]        best_id;
  logic signed [ACC_W-1:0] best;
  logic [CID_W-1:0]        class_id_q;
  logic signed [ACC_W-1:0] class_score_q;

  assign fire          = bus.pix_valid && pix_rdy;
  assign bus.pix_ready = pix_rdy;
  assign bus.wgt_en    = rom_en;
  assign bus.wgt_addr  = wgt_addr_q;

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    pix_rdy  = 1'b0;
    rom_en   = 1'b0;
    busy     = 1'b1;
    done     = 1'b0;
    ag_start = 1'b0;
    case (state_q)
      S_IDLE: begin
        busy = 1'b0;
        if (start) state_d = S_ACCUM;
      end
      S_ACCUM: begin
        pix_rdy = 1'b1;
        rom_en  = 1'b1;
        if (fire && pix_cnt == ADDR_W'(N_PIX - 1)) state_d = S_BIAS;
      end
      S_BIAS: begin
        rom_en  = 1'b1;
        state_d = S_ADDB;
      end
      S_ADDB: begin
        ag_start = 1'b1;
        state_d  = S_ARGMAX;
      end
      S_ARGMAX: begin
        if (ag_fin) state_d = S_DONE;
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // After the last fire wgt_addr lands on N_PIX, which is the bias row read in BIAS.
  always_ff @(posedge clk) begin
    if (rst) begin
      pix_cnt       <= '0;
      wgt_addr_q    <= '0;
      pix_reg       <= '0;
      mac_vld       <= 1'b0;
      class_id_q    <= '0;
      class_score_q <= '0;
    end else begin
      mac_vld <= fire;
      if (fire) pix_reg <= bus.pix_data;
      case (state_q)
        S_IDLE: if (start) begin
          pix_cnt    <= '0;
          wgt_addr_q <= '0;
        end
        S_ACCUM: if (fire) begin
          pix_cnt    <= pix_cnt + ADDR_W'(1);
          wgt_addr_q <= pix_cnt + ADDR_W'(1);
        end
        S_DONE: begin
          class_id_q    <= best_id;
          class_score_q <= best;
        end
        default: ;
      endcase
    end
  end

  for (genvar c = 0; c < N_CLASS; c++) begin : g_mac
    logic signed [WGT_W-1:0]  w;
    logic signed [PIX_W:0]    pix_s;
    logic signed [PROD_W-1:0] prod;
    logic signed [ACC_W-1:0]  acc_q, acc_d;

    assign w     = $signed(bus.wgt_rdata[wslice(c, WGT_W) +: WGT_W]);
    assign pix_s = $signed({1'b0, pix_reg});
    assign prod  = pix_s * w;

    always_comb begin
      acc_d = acc_q;
      if (state_q == S_IDLE && start)
        acc_d = '0;
      else if (mac_vld)
        acc_d = acc_q + {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};
      else if (state_q == S_ADDB)
        acc_d = acc_q + {{(ACC_W-WGT_W){w[WGT_W-1]}}, w};
    end

    always_ff @(posedge clk) begin
      if (rst) acc_q <= '0;
      else     acc_q <= acc_d;
    end

    // argmax sees the post-bias values at its start edge
    assign acc_flat[c*ACC_W +: ACC_W] = acc_d;
  end

  char_argmax_seq #(
    .N     (N_CLASS),
    .ACC_W (ACC_W),
    .IDX_W (CID_W)
  ) u_argmax (
    .clk     (clk),
    .rst     (rst),
    .start   (ag_start),
    .vec     (acc_flat),
    .fin     (ag_fin),
    .best_id (best_id),
    .best    (best)
  );

  assign class_id    = (state_q == S_DONE) ? best_id : class_id_q;
  assign class_score = (state_q == S_DONE) ? best    : class_score_q;

endmodule

// File: tb/tb_char_classify_core.sv
// Scoreboard bench for char_classify_core with a small image and a behavioural weight ROM.
module tb_char_classify_core;

  localparam int NP  = 4;
  localparam int NC  = 3;
  localparam int PW  = 8;
  localparam int WW  = 8;
  localparam int AW  = 32;
  localparam int ADW = 3;

  typedef int px_t[NP];
  typedef int wt_t[NP+1][NC];
  typedef struct {
    int id;
    int score;
  } exp_t;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 start;
  logic                 busy;
  logic                 done;
  logic [1:0]           class_id;
  logic signed [AW-1:0] class_score;

  char_classify_core_if #(.PIX_W(PW), .WGT_W(WW), .N_CLASS(NC), .ADDR_W(ADW)) bus ();

  char_classify_core #(
    .N_PIX(NP), .N_CLASS(NC), .PIX_W(PW), .WGT_W(WW), .ACC_W(AW), .ADDR_W(ADW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .bus         (bus),
    .busy        (busy),
    .done        (done),
    .class_id    (class_id),
    .class_score (class_score)
  );

  always #5 clk = ~clk;

  int     n_chk = 0;
  int     n_err = 0;
  longint cyc = 0;
  longint last_fire = 0;
  int     fires = 0;
  exp_t   sb[$];
  logic [NC*WW-1:0] rom [0:(1<<ADW)-1];

  px_t basic_px  = '{1, 2, 3, 4};
  wt_t basic_wt  = '{'{1, 2, 0}, '{1, 0, 0}, '{1, 0, 0}, '{1, 0, 5}, '{0, 0, 0}};
  px_t signed_px = '{255, 255, 0, 0};
  wt_t signed_wt = '{'{-128, 0, 0}, '{-128, 0, 0}, '{0, 0, 0}, '{0, 0, 0}, '{0, -1, -2}};
  wt_t tie_wt    = '{'{0, 0, 0}, '{0, 0, 0}, '{0, 0, 0}, '{0, 0, 0}, '{3, 3, 1}};

  task automatic chk(input string tag, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus.wgt_en) bus.wgt_rdata <= rom[bus.wgt_addr];
  end

  // Output monitor: address tracking during ACCUM and scoreboard pop on done.
  always @(negedge clk) begin
    exp_t e;
    if (!busy) begin
      fires = 0;
    end else if (bus.pix_ready) begin
      chk("wgt_addr", longint'(bus.wgt_addr), longint'(fires));
      if (bus.pix_valid) begin
        fires++;
        last_fire = cyc;
      end
    end
    if (done) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        e = sb.pop_front();
        chk("class_id", longint'(class_id), longint'(e.id));
        chk("class_score", longint'(class_score), longint'(e.score));
        chk("latency", cyc - last_fire, NC + 2);
      end
    end
  end

  task automatic load_rom(input wt_t wt);
    for (int r = 0; r < (1 << ADW); r++) rom[r] = '0;
    for (int r = 0; r <= NP; r++)
      for (int c = 0; c < NC; c++)
        rom[r][c*WW +: WW] = WW'(wt[r][c]);
  endtask

  task automatic send(input px_t px, input int n, input bit bub, input bit pulse);
    bit ok;
    for (int i = 0; i < n; i++) begin
      bus.pix_data  = PW'(px[i]);
      bus.pix_valid = 1'b1;
      if (pulse && i == 2) start = 1'b1;
      ok = 1'b0;
      for (int k = 0; k < 20 && !ok; k++) begin
        @(negedge clk);
        ok = bus.pix_ready;
      end
      if (!ok) chk("accept_timeout", 0, 1);
      @(posedge clk); #1;
      start         = 1'b0;
      bus.pix_valid = 1'b0;
      if (bub) repeat (2) begin
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic wait_done();
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 40 && !ok; k++) begin
      @(negedge clk);
      ok = done;
    end
    if (!ok) chk("done_timeout", 0, 1);
    @(posedge clk); #1;
  endtask

  task automatic run_image(input px_t px, input wt_t wt, input bit bub, input bit pulse);
    exp_t e;
    int   s;
    load_rom(wt);
    e.id = 0;
    e.score = 0;
    for (int c = 0; c < NC; c++) begin
      s = wt[NP][c];
      for (int i = 0; i < NP; i++) s += px[i] * wt[i][c];
      if (c == 0 || s > e.score) begin
        e.id = c;
        e.score = s;
      end
    end
    sb.push_back(e);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    send(px, NP, bub, pulse);
    wait_done();
  endtask

  initial begin
    rst           = 1'b1;
    start         = 1'b0;
    bus.pix_valid = 1'b0;
    bus.pix_data  = '0;
    for (int r = 0; r < (1 << ADW); r++) rom[r] = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_pix_ready", bus.pix_ready, 0);
    chk("rst_wgt_en", bus.wgt_en, 0);
    chk("rst_wgt_addr", bus.wgt_addr, 0);
    chk("rst_class_id", class_id, 0);
    chk("rst_class_score", class_score, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    run_image(basic_px, basic_wt, 1'b0, 1'b0);
    run_image(signed_px, signed_wt, 1'b0, 1'b0);
    run_image(basic_px, tie_wt, 1'b0, 1'b0);
    run_image(basic_px, basic_wt, 1'b1, 1'b0);

    // abort after two accepted pixels
    load_rom(basic_wt);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    send(basic_px, 2, 1'b0, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("busy_after_rst", busy, 0);
    chk("wgt_addr_after_rst", bus.wgt_addr, 0);
    repeat (10) @(negedge clk);
    @(posedge clk); #1;
    run_image(basic_px, basic_wt, 1'b0, 1'b0);

    // back-to-back, with a start pulse while busy
    run_image(basic_px, tie_wt, 1'b0, 1'b1);
    chk("sb_empty", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
